// File: rtl/sdn_parser_action_arbiter.sv
// Round-robin read arbiter and control-plane write path for the parser action RAM, with RAW hazard blocking.
// Optional macro SDN_ACT_ARB_BYPASS_EN: forward in-flight write data to hazarding reads instead of blocking them.
module sdn_parser_action_arbiter #(
   parameter int unsigned DATA_W  = 512,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic                      rsp_valid_o,
   output logic [IDX_W-1:0]          rsp_id_o,
   output logic [DATA_W-1:0]         rsp_data_o,
   input  logic                      rsp_ready_i,
   input  logic                      cfg_wr_valid_i,
   input  logic [ADDR_W-1:0]         cfg_wr_addr_i,
   input  logic [DATA_W-1:0]         cfg_wr_data_i,
   output logic                      cfg_wr_ready_o,
   output logic                      ram_en_a_o,
   output logic [ADDR_W-1:0]         ram_wraddr_a_o,
   output logic [DATA_W-1:0]         ram_wrdata_a_o,
   output logic                      ram_rden_b_o,
   output logic [ADDR_W-1:0]         ram_rdaddr_b_o,
   input  logic [DATA_W-1:0]         ram_rddata_b_i
);

   logic                cfg_wr_ready_q;
   logic                ram_en_a_q;
   logic [ADDR_W-1:0]   ram_wraddr_a_q;
   logic [DATA_W-1:0]   ram_wrdata_a_q;
   logic                hz2_v_q;
   logic [ADDR_W-1:0]   hz2_addr_q;
`ifdef SDN_ACT_ARB_BYPASS_EN
   logic [DATA_W-1:0]   hz2_data_q;
`endif
   logic                rsp_valid_q, rsp_valid_d;
   logic [IDX_W-1:0]    rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;

   logic                wr_acc_c;
   logic                slot_free_c;
   logic                gnt_c;
   logic [IDX_W-1:0]    gidx_c;
   logic [IDX_W-1:0]    cand_c;
   logic [NUM_REQ-1:0]  elig_c;
   logic [NUM_REQ-1:0]  req_ready_c;
   logic [ADDR_W-1:0]   rd_addr_c;
   logic [DATA_W-1:0]   rd_data_c;
   logic [ADDR_W-1:0]   req_addr_c [NUM_REQ];

   assign wr_acc_c = cfg_wr_valid_i & cfg_wr_ready_q;

   // Hazard window: incoming accept (T), the RAM port register (T-1) and hz2 (T-2).
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
      assign req_addr_c[k] = req_addr_i[k*ADDR_W +: ADDR_W];
`ifdef SDN_ACT_ARB_BYPASS_EN
      assign elig_c[k] = req_valid_i[k];
`else
      assign elig_c[k] = req_valid_i[k] &
                         ~((wr_acc_c   & (req_addr_c[k] == cfg_wr_addr_i))  |
                           (ram_en_a_q & (req_addr_c[k] == ram_wraddr_a_q)) |
                           (hz2_v_q    & (req_addr_c[k] == hz2_addr_q)));
`endif
   end

   // Round-robin pick of the first eligible requester after the pointer.
   always_comb begin
      gnt_c       = 1'b0;
      gidx_c      = '0;
      cand_c      = '0;
      req_ready_c = '0;
      slot_free_c = ~rsp_valid_q | rsp_ready_i;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand_c = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
         if (!gnt_c && cfg_wr_ready_q && slot_free_c && elig_c[cand_c]) begin
            gnt_c  = 1'b1;
            gidx_c = cand_c;
         end
      end
      if (gnt_c) req_ready_c[gidx_c] = 1'b1;
   end

   assign rd_addr_c = req_addr_c[gidx_c];

`ifdef SDN_ACT_ARB_BYPASS_EN
   // Youngest in-flight write to the read address wins over the stale RAM contents.
   always_comb begin
      rd_data_c = ram_rddata_b_i;
      if (wr_acc_c && (rd_addr_c == cfg_wr_addr_i)) begin
         rd_data_c = cfg_wr_data_i;
      end else if (ram_en_a_q && (rd_addr_c == ram_wraddr_a_q)) begin
         rd_data_c = ram_wrdata_a_q;
      end else if (hz2_v_q && (rd_addr_c == hz2_addr_q)) begin
         rd_data_c = hz2_data_q;
      end
   end
`else
   assign rd_data_c = ram_rddata_b_i;
`endif

   // Response slot and pointer next state.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      ptr_d       = ptr_q;
      if (gnt_c) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = gidx_c;
         rsp_data_d  = rd_data_c;
         ptr_d       = gidx_c;
      end else if (rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cfg_wr_ready_q <= 1'b0;
         ram_en_a_q     <= 1'b0;
         ram_wraddr_a_q <= '0;
         ram_wrdata_a_q <= '0;
         hz2_v_q        <= 1'b0;
         hz2_addr_q     <= '0;
`ifdef SDN_ACT_ARB_BYPASS_EN
         hz2_data_q     <= '0;
`endif
         rsp_valid_q    <= 1'b0;
         rsp_id_q       <= '0;
         rsp_data_q     <= '0;
         ptr_q          <= IDX_W'(NUM_REQ - 1);
      end else begin
         cfg_wr_ready_q <= 1'b1;
         ram_en_a_q     <= wr_acc_c;
         if (wr_acc_c) begin
            ram_wraddr_a_q <= cfg_wr_addr_i;
            ram_wrdata_a_q <= cfg_wr_data_i;
         end
         hz2_v_q        <= ram_en_a_q;
         hz2_addr_q     <= ram_wraddr_a_q;
`ifdef SDN_ACT_ARB_BYPASS_EN
         hz2_data_q     <= ram_wrdata_a_q;
`endif
         rsp_valid_q    <= rsp_valid_d;
         rsp_id_q       <= rsp_id_d;
         rsp_data_q     <= rsp_data_d;
         ptr_q          <= ptr_d;
      end
   end

   assign req_ready_o    = req_ready_c;
   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_id_o       = rsp_id_q;
   assign rsp_data_o     = rsp_data_q;
   assign cfg_wr_ready_o = cfg_wr_ready_q;
   assign ram_en_a_o     = ram_en_a_q;
   assign ram_wraddr_a_o = ram_wraddr_a_q;
   assign ram_wrdata_a_o = ram_wrdata_a_q;
   assign ram_rden_b_o   = gnt_c;
   assign ram_rdaddr_b_o = rd_addr_c;

endmodule
